// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU: one quotient bit per
// clock, with divide-by-zero and signed-overflow results preloaded without iterating.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor_mag;
   logic [CW-1:0]    count;
   logic             signed_mode;
   logic             quo_neg;
   logic             rem_neg;
   logic             fix_en;

   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_in_mag;
   logic             div_zero;
   logic             overflow;
   logic [WIDTH:0]   trial;

   // Operand magnitudes and special-case detection on the raw start inputs.
   // The partial remainder always stays below the divisor, so WIDTH bits plus
   // the shifted-in quotient bit form the full WIDTH+1-bit trial subtraction.
   always_comb begin
      dividend_mag   = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
      divisor_in_mag = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;
      div_zero       = (i_divisor == '0);
      overflow       = i_signed && (i_dividend == MIN_INT) && (i_divisor == ALL_ONES);
      trial          = {rem, quo[WIDTH-1]} - {1'b0, divisor_mag};
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (i_start) state_next = (div_zero || overflow) ? FIX : CALC;
         CALC: if (count == CW'(WIDTH - 1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   // Datapath: operand capture, one restoring step per CALC cycle, and sign
   // fix-up into the result registers on the way into DONE.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rem         <= '0;
         quo         <= '0;
         divisor_mag <= '0;
         count       <= '0;
         signed_mode <= 1'b0;
         quo_neg     <= 1'b0;
         rem_neg     <= 1'b0;
         fix_en      <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  signed_mode <= i_signed;
                  quo_neg     <= i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                  rem_neg     <= i_signed && i_dividend[WIDTH-1];
                  divisor_mag <= divisor_in_mag;
                  count       <= '0;
                  if (div_zero) begin
                     quo    <= ALL_ONES;
                     rem    <= i_dividend;
                     fix_en <= 1'b0;
                  end else if (overflow) begin
                     quo    <= i_dividend;
                     rem    <= '0;
                     fix_en <= 1'b0;
                  end else begin
                     quo    <= dividend_mag;
                     rem    <= '0;
                     fix_en <= 1'b1;
                  end
               end
            end
            CALC: begin
               count <= count + 1'b1;
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               o_quotient  <= (fix_en && signed_mode && quo_neg) ? -quo : quo;
               o_remainder <= (fix_en && signed_mode && rem_neg) ? -rem : rem;
            end
            default: ;
         endcase
      end
   end

   assign o_busy = (state == CALC) || (state == FIX);
   assign o_done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner-case sequences
// (start while busy, reset mid-calculation) and random operands against a model.
module tb_div_unit;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic        i_signed;
   logic [31:0] i_dividend;
   logic [31:0] i_divisor;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_quotient;
   logic [31:0] o_remainder;

   int total_checks = 0;
   int passed_checks = 0;

   typedef struct {
      logic [31:0] dividend;
      logic [31:0] divisor;
      logic        sgn;
      logic [31:0] exp_q;
      logic [31:0] exp_r;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   div_unit #(.WIDTH(32)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_start(i_start),
      .i_signed(i_signed),
      .i_dividend(i_dividend),
      .i_divisor(i_divisor),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_quotient(o_quotient),
      .o_remainder(o_remainder)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      else
         passed_checks++;
   endtask

   // Reference: RISC-V division results from plain integer arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output int lat);
      longint sa;
      longint sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; lat = 1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 32'd0; lat = 1;
      end else if (s) begin
         q = 32'(sa / sb); r = 32'(sa % sb); lat = 33;
      end else begin
         q = a / b; r = a % b; lat = 33;
      end
   endfunction

   // Issues one operation and waits (bounded) for o_done; latency counts edges after the start edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output int lat, output int busy_cnt, output logic done_after);
      @(negedge i_clk);
      i_dividend = a;
      i_divisor  = b;
      i_signed   = s;
      i_start    = 1'b1;
      @(posedge i_clk);
      #1;
      i_start    = 1'b0;
      i_dividend = $urandom;
      i_divisor  = $urandom;
      lat = 0;
      busy_cnt = 0;
      while (!o_done && lat < 100) begin
         if (o_busy) busy_cnt++;
         @(posedge i_clk);
         #1;
         lat++;
      end
      q = o_quotient;
      r = o_remainder;
      @(posedge i_clk);
      #1;
      done_after = o_done;
   endtask

   task automatic runAndCheck(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic [31:0] eq, input logic [31:0] er, input int elat);
      logic [31:0] q, r;
      int lat, busy_cnt;
      logic done_after;
      applyStimulus(a, b, s, q, r, lat, busy_cnt, done_after);
      checkOutput({name, " quotient"}, q, eq);
      checkOutput({name, " remainder"}, r, er);
      checkOutput({name, " latency"}, 32'(lat), 32'(elat));
      checkOutput({name, " busy cycles"}, 32'(busy_cnt), 32'(elat));
      checkOutput({name, " done one cycle"}, {31'd0, done_after}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, eq, er, q, r;
      logic        s;
      int          elat, done_cnt;

      vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
      vecs[1] = '{32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
      vecs[2] = '{32'h0000_0007,  32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'h0000_0001,  33};
      vecs[3] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1};
      vecs[4] = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1};
      vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1};
      vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  33};
      vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          33};
      vecs[8] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          33};
      vecs[9] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  33};

      i_rst = 1'b1;
      i_start = 1'b0;
      i_signed = 1'b0;
      i_dividend = '0;
      i_divisor = '0;
      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("reset busy", {31'd0, o_busy}, 32'd0);
      checkOutput("reset done", {31'd0, o_done}, 32'd0);
      checkOutput("reset quotient", o_quotient, 32'd0);
      checkOutput("reset remainder", o_remainder, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      for (int i = 0; i < 10; i++)
         runAndCheck($sformatf("vec%0d", i), vecs[i].dividend, vecs[i].divisor, vecs[i].sgn,
                     vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_lat);

      // Second start while busy must be ignored.
      @(negedge i_clk);
      i_dividend = 32'd100; i_divisor = 32'd7; i_signed = 1'b0; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (4) @(negedge i_clk);
      i_dividend = 32'd50; i_divisor = 32'd3; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      done_cnt = 0;
      q = '0; r = '0;
      for (int c = 0; c < 80; c++) begin
         @(posedge i_clk);
         #1;
         if (o_done) begin
            if (done_cnt == 0) begin q = o_quotient; r = o_remainder; end
            done_cnt++;
         end
      end
      checkOutput("busy-start quotient", q, 32'd14);
      checkOutput("busy-start remainder", r, 32'd2);
      checkOutput("busy-start done count", 32'(done_cnt), 32'd1);

      // Reset at iteration 10 aborts silently.
      @(negedge i_clk);
      i_dividend = 32'hDEAD_BEEF; i_divisor = 32'd3; i_signed = 1'b0; i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (10) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      #1;
      checkOutput("abort busy", {31'd0, o_busy}, 32'd0);
      checkOutput("abort done", {31'd0, o_done}, 32'd0);
      checkOutput("abort quotient", o_quotient, 32'd0);
      checkOutput("abort remainder", o_remainder, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge i_clk);
         #1;
         if (o_done) done_cnt++;
      end
      checkOutput("abort no done", 32'(done_cnt), 32'd0);
      runAndCheck("post-abort", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33);

      // Random operands against the model.
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'($urandom_range(1, 15));
            1: b = -32'($urandom_range(1, 15));
            2: b = 32'd0;
            3: begin a = 32'h8000_0000; b = (n % 2 == 0) ? 32'hFFFF_FFFF : $urandom; end
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         s = 1'($urandom_range(0, 1));
         model(a, b, s, eq, er, elat);
         runAndCheck($sformatf("rand%0d", n), a, b, s, eq, er, elat);
      end

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
